// File: rtl/pixel_stream_sequencer.sv
// Walks the pixel mux select over all entries and re-times the combinational mux
// output into a registered valid/ready stream, prefetching one entry ahead.
//
// state  | meaning
// IDLE   | Select parked at 0, waiting for Start
// LOAD   | capture entry 0, raise Valid, point Select at entry 1
// STREAM | emit beats; on accept capture the prefetched entry
// DONE   | one-cycle Done pulse, then back to IDLE
module pixel_stream_sequencer #(
    parameter int PIX_WIDTH = 70,
    parameter int NUM_PIX   = 112,
    parameter int SEL_BIT   = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Start,
    input  logic                 Abort,
    input  logic [PIX_WIDTH-1:0] Pixel_In,
    output logic [SEL_BIT-1:0]   Select,
    output logic [PIX_WIDTH-1:0] Pixel_Out,
    output logic [SEL_BIT-1:0]   Pixel_Index,
    output logic                 Valid,
    input  logic                 Ready,
    output logic                 Last,
    output logic                 Busy,
    output logic                 Done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DONE
    } state_t;

    localparam logic [SEL_BIT-1:0] LAST_IDX = SEL_BIT'(NUM_PIX - 1);

    state_t               r_state;
    logic [SEL_BIT-1:0]   r_select;
    logic [SEL_BIT-1:0]   r_index;
    logic [PIX_WIDTH-1:0] r_pixel;
    logic                 r_valid;
    logic                 r_done;

    logic w_accept;
    logic w_last_beat;
    logic w_sel_sat;

    assign w_accept    = r_valid & Ready;
    assign w_last_beat = (r_index == LAST_IDX);
    assign w_sel_sat   = (r_select == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_select <= '0;
            r_index  <= '0;
            r_pixel  <= '0;
            r_valid  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_select <= '0;
                    r_valid  <= 1'b0;
                    if (Start) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (Abort) begin
                        r_state  <= S_IDLE;
                        r_select <= '0;
                        r_index  <= '0;
                        r_valid  <= 1'b0;
                    end else begin
                        r_pixel  <= Pixel_In;
                        r_index  <= '0;
                        r_valid  <= 1'b1;
                        r_select <= SEL_BIT'(1);
                        r_state  <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    // Abort takes priority over a beat accepted in the same cycle.
                    if (Abort) begin
                        r_state  <= S_IDLE;
                        r_select <= '0;
                        r_index  <= '0;
                        r_valid  <= 1'b0;
                    end else if (w_accept) begin
                        if (w_last_beat) begin
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_pixel  <= Pixel_In;
                            r_index  <= r_index + SEL_BIT'(1);
                            r_select <= w_sel_sat ? r_select : r_select + SEL_BIT'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_select <= '0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_select <= '0;
                    r_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign Select      = r_select;
    assign Pixel_Out   = r_pixel;
    assign Pixel_Index = r_index;
    assign Valid       = r_valid;
    assign Done        = r_done;
    assign Last        = r_valid & w_last_beat;
    assign Busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// Self-checking bench: a behavioural mux model feeds the sequencer, and each run is
// checked against an expected ordered beat list and a cycle-count timing model.
module tb_pixel_stream_sequencer;

    localparam int PW = 70;
    localparam int NP = 112;
    localparam int SB = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic          Ready = 1'b0;
    logic [PW-1:0] Pixel_In;
    logic [SB-1:0] Select;
    logic [PW-1:0] Pixel_Out;
    logic [SB-1:0] Pixel_Index;
    logic          Valid, Last, Busy, Done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pixel_stream_sequencer #(.PIX_WIDTH(PW), .NUM_PIX(NP), .SEL_BIT(SB)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Abort(Abort),
        .Pixel_In(Pixel_In), .Select(Select), .Pixel_Out(Pixel_Out),
        .Pixel_Index(Pixel_Index), .Valid(Valid), .Ready(Ready),
        .Last(Last), .Busy(Busy), .Done(Done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] ent(input int i);
        logic [6:0] b;
        b = i[6:0];
        return {10{b}};
    endfunction

    // Static mux contents: entry i is its own index replicated.
    always_comb Pixel_In = (int'(Select) < NP) ? ent(int'(Select)) : '0;

    // Drives one run and checks it against the ordered beat list 0..NP-1.
    // Negative beat arguments disable the corresponding disturbance.
    task automatic run_and_check(input string nm, input int ready_pct, input bit start_with_abort,
                                 input int start_beat, input bit start_in_done,
                                 input int abort_beat, input int rst_beat);
        int  exp_idx = 0;
        int  stalls  = 0;
        int  k0;
        bit  seen_valid = 0;
        bit  fin = 0;
        @(negedge clk);
        Start = 1'b1;
        Abort = start_with_abort;
        Ready = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        Abort = 1'b0;
        k0 = cyc;
        for (int t = 0; t < 3000 && !fin; t++) begin
            if (t > 0) @(negedge clk);
            Start = 1'b0;
            if (Done) begin
                n_checks++;
                if (cyc - k0 !== NP + 1 + stalls) begin
                    n_fail++;
                    $display("FAIL %s done_cycle: got k+%0d want k+%0d", nm, cyc - k0, NP + 1 + stalls);
                end
                n_checks++;
                if (exp_idx !== NP) begin
                    n_fail++;
                    $display("FAIL %s beat_count: got %0d want %0d", nm, exp_idx, NP);
                end
                if (start_in_done) Start = 1'b1;
                @(negedge clk);
                Start = 1'b0;
                n_checks++;
                if (Done !== 1'b0 || Busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s done_pulse_end: got done=%0b busy=%0b want 0 0", nm, Done, Busy);
                end
                fin = 1;
            end else begin
                if (Valid) begin
                    if (!seen_valid) begin
                        seen_valid = 1;
                        n_checks++;
                        if (cyc - k0 !== 1) begin
                            n_fail++;
                            $display("FAIL %s first_valid: got k+%0d want k+1", nm, cyc - k0);
                        end
                    end
                    n_checks++;
                    if (Pixel_Index !== SB'(exp_idx) || Pixel_Out !== ent(exp_idx)) begin
                        n_fail++;
                        $display("FAIL %s beat: got idx=%0d data=%h want idx=%0d data=%h",
                                 nm, Pixel_Index, Pixel_Out, exp_idx, ent(exp_idx));
                    end
                    n_checks++;
                    if (Last !== (exp_idx == NP - 1)) begin
                        n_fail++;
                        $display("FAIL %s last: got %0b want %0b at idx %0d", nm, Last, exp_idx == NP - 1, exp_idx);
                    end
                end else if (seen_valid) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s valid_dropped: got 0 want 1 at idx %0d", nm, exp_idx);
                end
                if (Select > SB'(NP - 1)) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL %s select_range: got %0d want <= %0d", nm, Select, NP - 1);
                end
                Ready = ($urandom_range(0, 99) < ready_pct);
                if (Valid && exp_idx == abort_beat) begin
                    Abort = 1'b1;
                    Ready = 1'b1;
                    @(negedge clk);
                    Abort = 1'b0;
                    n_checks++;
                    if (Valid !== 1'b0 || Select !== '0 || Pixel_Index !== '0 || Busy !== 1'b0 || Done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s abort: got v=%0b sel=%0d idx=%0d busy=%0b done=%0b want all 0",
                                 nm, Valid, Select, Pixel_Index, Busy, Done);
                    end
                    for (int j = 0; j < 5; j++) begin
                        @(negedge clk);
                        n_checks++;
                        if (Done !== 1'b0 || Busy !== 1'b0) begin
                            n_fail++;
                            $display("FAIL %s abort_idle: got done=%0b busy=%0b want 0 0", nm, Done, Busy);
                        end
                    end
                    fin = 1;
                end else if (Valid && exp_idx == rst_beat) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    n_checks++;
                    if (Valid !== 1'b0 || Select !== '0 || Pixel_Index !== '0 || Pixel_Out !== '0 ||
                        Busy !== 1'b0 || Done !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s async_reset: got v=%0b sel=%0d idx=%0d data=%h busy=%0b done=%0b want all 0",
                                 nm, Valid, Select, Pixel_Index, Pixel_Out, Busy, Done);
                    end
                    @(negedge clk);
                    n_checks++;
                    if (Done !== 1'b0 || Busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL %s reset_hold: got done=%0b busy=%0b want 0 0", nm, Done, Busy);
                    end
                    rst_n = 1'b1;
                    @(negedge clk);
                    fin = 1;
                end else begin
                    if (Valid && exp_idx == start_beat) Start = 1'b1;
                    if (Valid) begin
                        if (Ready) exp_idx++;
                        else stalls++;
                    end
                end
            end
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got idx=%0d want run end", nm, exp_idx);
        end
        Ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (Select !== '0 || Pixel_Out !== '0 || Pixel_Index !== '0 || Valid !== 1'b0 ||
            Done !== 1'b0 || Last !== 1'b0 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got sel=%0d data=%h idx=%0d v=%0b d=%0b l=%0b b=%0b want all 0",
                     Select, Pixel_Out, Pixel_Index, Valid, Done, Last, Busy);
        end
        rst_n = 1'b1;
        Abort = 1'b1;
        @(negedge clk);
        Abort = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (Select !== '0 || Busy !== 1'b0 || Valid !== 1'b0 || Done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got sel=%0d busy=%0b v=%0b d=%0b want 0 0 0 0", Select, Busy, Valid, Done);
        end
    endtask

    task automatic test_full_run();
        run_and_check("full_run", 100, 1'b0, -1, 1'b0, -1, -1);
    endtask

    task automatic test_backpressure();
        run_and_check("backpressure_a", 60, 1'b0, -1, 1'b0, -1, -1);
        run_and_check("backpressure_b", 25, 1'b0, -1, 1'b0, -1, -1);
    endtask

    task automatic test_start_busy();
        run_and_check("start_busy", 100, 1'b0, 50, 1'b1, -1, -1);
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (Busy !== 1'b0 || Valid !== 1'b0) begin
                n_fail++;
                $display("FAIL start_busy_no_rerun: got busy=%0b v=%0b want 0 0", Busy, Valid);
            end
        end
    endtask

    task automatic test_start_abort_idle();
        run_and_check("start_abort_idle", 100, 1'b1, -1, 1'b0, -1, -1);
    endtask

    task automatic test_abort();
        run_and_check("abort", 100, 1'b0, -1, 1'b0, 30, -1);
        run_and_check("after_abort", 80, 1'b0, -1, 1'b0, -1, -1);
    endtask

    task automatic test_async_reset();
        run_and_check("async_reset", 80, 1'b0, -1, 1'b0, -1, 70);
        run_and_check("after_reset", 100, 1'b0, -1, 1'b0, -1, -1);
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_start_busy();
        test_start_abort_idle();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
